mult_seq: RTL and testbench

Parametrised sequential multiplier: the multi-cycle, slice-based successor of the fixed 32×32 multiplier. It generalises operand width and partial-product slice width, and adds a per-operation signed/unsigned mode and a one-cycle completion pulse. It sits beside the datapath as a start/busy coprocessor: the requester pulses `start` with the operands and reads `product` when `done` pulses.

---
 rtl/mult_seq_pkg.sv | 29 ++
 rtl/mult_seq_datapath.sv | 89 ++++++++
 rtl/mult_seq.sv | 142 ++++++++++++++
 tb/tb_mult_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Purpose : shared types and elaboration-time helpers for the sequential multiplier.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_e        - controller state encoding (IDLE / RUN)
//   pp_count()     - number of SLICE x SLICE partial products for a WIDTH x WIDTH multiply
//   idx_width()    - bits needed to walk the partial-product index (never less than 1)
package mult_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // N slices per operand, every slice of a crossed with every slice of b.
    function automatic int pp_count(input int width, input int slice);
        return (width / slice) * (width / slice);
    endfunction

    // A single-product build (WIDTH == SLICE) still needs a 1-bit index so
    // that port and register declarations stay legal.
    function automatic int idx_width(input int width, input int slice);
        int p;
        p = pp_count(width, slice);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage : mult_seq_pkg

// File: rtl/mult_seq_datapath.sv
// Purpose : slice-select, SLICE x SLICE multiply, shift and 2*WIDTH accumulate.
// Latency : one partial product per cycle; sum_nxt is combinational from acc + current product.
// Backpressure: none; the controller sequences idx/clr/add_en and holds operands stable.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   a_mag, b_mag    - unsigned operand magnitudes (held by the controller during a run)
//   idx             - partial-product index {i, j}, j fastest
//   clr             - zero the accumulator at the next edge (wins over add_en)
//   add_en          - accumulate the current shifted partial product at the next edge
//   sum_nxt         - accumulator plus the current shifted partial product
module mult_seq_datapath
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int IW    = idx_width(WIDTH, SLICE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    input  logic [IW-1:0]        idx,
    input  logic                 clr,
    input  logic                 add_en,
    output logic [2*WIDTH-1:0]   sum_nxt
);

    localparam int N  = WIDTH / SLICE;
    localparam int AW = 2 * WIDTH;
    // Width of a per-operand slice number; kept >= 1 for the degenerate N == 1 build.
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] N_IDX = IW'(N);

    // Operands split into SLICE-wide pieces, slice 0 is least significant.
    logic [SLICE-1:0] a_sl [N];
    logic [SLICE-1:0] b_sl [N];

    for (genvar k = 0; k < N; k++) begin : g_slices
        assign a_sl[k] = a_mag[k*SLICE +: SLICE];
        assign b_sl[k] = b_mag[k*SLICE +: SLICE];
    end

    logic [SW-1:0]      i_idx;
    logic [SW-1:0]      j_idx;
    logic [SLICE-1:0]   a_slice;
    logic [SLICE-1:0]   b_slice;
    logic [2*SLICE-1:0] pp;
    logic [AW-1:0]      pp_shifted;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;

    // idx walks {i, j} with j fastest, so i = idx / N and j = idx % N.
    // N need not be a power of two; these are constant divisors.
    always_comb begin
        i_idx = SW'(idx / N_IDX);
        j_idx = SW'(idx % N_IDX);
    end

    always_comb begin
        a_slice = a_sl[i_idx];
        b_slice = b_sl[j_idx];
        pp      = {{SLICE{1'b0}}, a_slice} * {{SLICE{1'b0}}, b_slice};
        // Weight of slice pair (i, j) is 2^((i+j)*SLICE); the largest shift
        // is 2*(N-1)*SLICE, so the product always lands inside AW bits.
        pp_shifted = AW'(pp) << ((int'(i_idx) + int'(j_idx)) * SLICE);
        sum_nxt    = acc_q + pp_shifted;
    end

    // The sum of all partial products of two WIDTH-bit magnitudes is below
    // 2^(2*WIDTH), so this addition can never carry out.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = sum_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : mult_seq_datapath

// File: rtl/mult_seq.sv
// Purpose : start/busy sequential WIDTH x WIDTH multiplier, signed or unsigned per operation.
// Latency : P = (WIDTH/SLICE)^2 cycles from the accepting edge to the done pulse.
// Backpressure: start is ignored while busy=1; no queueing, captured operands untouched.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start           - request, sampled only while busy=0
//   a, b, is_signed - operands and mode, captured on the accepting edge
//   busy            - operation in progress (registered)
//   done            - one-cycle completion pulse (registered)
//   product         - last completed 2*WIDTH result, held until the next done
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int P  = pp_count(WIDTH, SLICE);
    localparam int IW = idx_width(WIDTH, SLICE);
    localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);

    if ((WIDTH % SLICE) != 0 || SLICE <= 0) begin : g_bad_cfg
        $error("mult_seq: WIDTH must be a positive multiple of SLICE");
    end

    // Two's-complement magnitude. The most negative value maps onto
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    state_e               state_q,   state_d;
    logic [IW-1:0]        idx_q,     idx_d;
    logic [WIDTH-1:0]     a_mag_q,   a_mag_d;
    logic [WIDTH-1:0]     b_mag_q,   b_mag_d;
    logic                 neg_q,     neg_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 acc_clr;
    logic                 acc_add;
    logic [2*WIDTH-1:0]   sum_nxt;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        product_d = product_q;
        done_d    = 1'b0;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_mag_d = magnitude(a, is_signed);
                    b_mag_d = magnitude(b, is_signed);
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    idx_d   = '0;
                    acc_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_add = 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Take the final sum straight from the adder so the result
                    // is ready on the same edge as the last accumulation.
                    product_d = neg_q ? (~sum_nxt + (2*WIDTH)'(1)) : sum_nxt;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    mult_seq_datapath #(
        .WIDTH (WIDTH),
        .SLICE (SLICE),
        .IW    (IW)
    ) u_datapath (
        .clk     (clk),
        .rst     (reset),
        .a_mag   (a_mag_q),
        .b_mag   (b_mag_q),
        .idx     (idx_q),
        .clr     (acc_clr),
        .add_en  (acc_add),
        .sum_nxt (sum_nxt)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// Purpose : directed bench for mult_seq in the 32/8, 32/16 and 16/4 builds.
// Latency : checks P-cycle busy windows and the done/product cycle.
// Backpressure: exercises start-while-busy rejection and start during the done cycle.
module tb_mult_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  start_v;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        sgn_in;

    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [63:0] prod0;
    logic [63:0] prod1;
    logic [31:0] prod2;

    int checks = 0;
    int errors = 0;

    mult_seq u_main (
        .clk       (clk),
        .reset     (reset),
        .start     (start_v[0]),
        .a         (a_in),
        .b         (b_in),
        .is_signed (sgn_in),
        .busy      (busy_v[0]),
        .done      (done_v[0]),
        .product   (prod0)
    );

    mult_seq #(.WIDTH(32), .SLICE(16)) u_p4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_v[1]),
        .a         (a_in),
        .b         (b_in),
        .is_signed (sgn_in),
        .busy      (busy_v[1]),
        .done      (done_v[1]),
        .product   (prod1)
    );

    mult_seq #(.WIDTH(16), .SLICE(4)) u_w16 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_v[2]),
        .a         (a_in[15:0]),
        .b         (b_in[15:0]),
        .is_signed (sgn_in),
        .busy      (busy_v[2]),
        .done      (done_v[2]),
        .product   (prod2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prod_of(input int sel);
        case (sel)
            0:       return prod0;
            1:       return prod1;
            default: return {32'b0, prod2};
        endcase
    endfunction

    // Reference product from plain wide multiplication of extended operands.
    function automatic logic [63:0] ref_mul(input int sel, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
        logic [31:0] x16, y16, r16;
        logic [63:0] x32, y32;
        if (sel == 2) begin
            x16 = s ? {{16{a[15]}}, a[15:0]} : {16'b0, a[15:0]};
            y16 = s ? {{16{b[15]}}, b[15:0]} : {16'b0, b[15:0]};
            r16 = x16 * y16;
            return {32'b0, r16};
        end
        x32 = s ? {{32{a[31]}}, a} : {32'b0, a};
        y32 = s ? {{32{b[31]}}, b} : {32'b0, b};
        return x32 * y32;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge,
    // with the operand inputs scrambled to show they are not re-sampled.
    task automatic launch(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        a_in         = a;
        b_in         = b;
        sgn_in       = s;
        start_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
        a_in         = ~a;
        b_in         = $urandom;
        sgn_in       = ~s;
    endtask

    // Counts busy cycles (bounded), optionally re-pulses start in busy cycle
    // 'inj', then checks the done cycle. Returns at the negedge of the done cycle.
    task automatic wait_done(input int sel, input int exp_p, input logic [63:0] exp_prod,
                             input string tag, input int inj);
        int cnt;
        int early;
        cnt   = 0;
        early = 0;
        while (busy_v[sel] && cnt < 200) begin
            if (done_v[sel]) early++;
            if (inj != 0 && cnt + 1 == inj) begin
                start_v[sel] = 1'b1;
                a_in         = 32'h1234_5678;
                b_in         = 32'h0BAD_F00D;
                sgn_in       = 1'b1;
            end else begin
                start_v[sel] = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        start_v[sel] = 1'b0;
        check({tag, " busy_cycles"}, 64'(cnt), 64'(exp_p));
        check({tag, " done_during_busy"}, 64'(early), 64'd0);
        check({tag, " done"}, {63'b0, done_v[sel]}, 64'd1);
        check({tag, " busy_in_done"}, {63'b0, busy_v[sel]}, 64'd0);
        check({tag, " product"}, prod_of(sel), exp_prod);
    endtask

    task automatic idle_after(input int sel, input logic [63:0] exp_prod, input string tag);
        @(negedge clk);
        check({tag, " done_clears"}, {63'b0, done_v[sel]}, 64'd0);
        check({tag, " stays_idle"}, {63'b0, busy_v[sel]}, 64'd0);
        check({tag, " product_held"}, prod_of(sel), exp_prod);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          stray;

        reset   = 1'b1;
        start_v = 3'b000;
        a_in    = '0;
        b_in    = '0;
        sgn_in  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'b0, busy_v[0]}, 64'd0);
        check("reset done", {63'b0, done_v[0]}, 64'd0);
        check("reset product", prod0, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset busy", {63'b0, busy_v[0]}, 64'd0);
        check("post_reset product_w16", prod_of(2), 64'd0);

        // Unsigned maximum: (2^32-1)^2.
        launch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(0, 16, 64'hFFFF_FFFE_0000_0001, "umax", 0);
        idle_after(0, 64'hFFFF_FFFE_0000_0001, "umax");

        // Signed edges: -2*3, and (-2^31)^2.
        launch(0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_done(0, 16, 64'hFFFF_FFFF_FFFF_FFFA, "sgn_m2x3", 0);
        launch(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(0, 16, 64'h4000_0000_0000_0000, "sgn_minsq", 0);

        // Same operands in both modes, chained through the done cycle.
        launch(0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done(0, 16, 64'hFFFF_FFFF_FFFF_FFFE, "mode_signed", 0);
        launch(0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_done(0, 16, 64'h0000_0001_FFFF_FFFE, "mode_unsigned", 0);
        idle_after(0, 64'h0000_0001_FFFF_FFFE, "mode_unsigned");

        // Start while busy is ignored; start in the done cycle is accepted.
        launch(0, 32'd7, 32'd9, 1'b0);
        wait_done(0, 16, 64'd63, "busy_start", 5);
        launch(0, 32'd5, 32'd6, 1'b0);
        wait_done(0, 16, 64'd30, "done_cycle_start", 0);
        idle_after(0, 64'd30, "done_cycle_start");

        // Reset in busy cycle 7 aborts asynchronously.
        launch(0, 32'd123, 32'd456, 1'b0);
        repeat (6) @(negedge clk);
        check("midrun busy_before_reset", {63'b0, busy_v[0]}, 64'd1);
        reset = 1'b1;
        #1;
        check("midrun busy", {63'b0, busy_v[0]}, 64'd0);
        check("midrun done", {63'b0, done_v[0]}, 64'd0);
        check("midrun product", prod0, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) stray++;
        end
        check("midrun no_done_after_abort", 64'(stray), 64'd0);
        launch(0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done(0, 16, 64'hC000_0000_8000_0000, "after_reset", 0);

        // 32/16 build: four partial products.
        launch(1, 32'h0C46_B736, 32'h1302_BF7F, 1'b0);
        wait_done(1, 4, ref_mul(1, 32'h0C46_B736, 32'h1302_BF7F, 1'b0), "p4", 0);
        launch(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(1, 4, 64'h0000_0000_8000_0000, "p4_signed", 0);

        // 16/4 build: boundaries, then random operands in random modes.
        launch(2, 32'h0000_8000, 32'h0000_8000, 1'b1);
        wait_done(2, 16, 64'h0000_0000_4000_0000, "w16_minsq", 0);
        launch(2, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        wait_done(2, 16, 64'h0000_0000_FFFE_0001, "w16_umax", 0);
        for (int t = 0; t < 6; t++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            launch(2, ra, rb, rs);
            wait_done(2, 16, ref_mul(2, ra, rb, rs), "w16_rand", 0);
        end
        idle_after(2, prod_of(2), "w16_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_mult_seq
